// File: rtl/decode_writeback.sv
// Y86-64 register-file stage: decodes source/destination IDs from fetched fields,
// reads the 15 x 64-bit register file and writes back valE/valM on the writeback strobe.
module decode_writeback (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_en,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        wb_en,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [3:0]  dstE_wb,
  output logic [3:0]  dstM_wb,
  output logic        inst_err,
  output logic [63:0] rsp
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  logic [63:0] regs_r [0:14];
  logic [3:0]  icode_q_r;
  logic [3:0]  ra_q_r;
  logic [3:0]  rb_q_r;

  logic [3:0]  src_a_s;
  logic [3:0]  src_b_s;
  logic [3:0]  dst_e_s;
  logic [3:0]  dst_m_s;
  logic [63:0] rd_a_s;
  logic [63:0] rd_b_s;

  // Source register selection from the live fetch fields
  always_comb begin
    src_a_s = RNONE;
    src_b_s = RNONE;
    case (icode)
      4'h2, 4'h4, 4'h6, 4'hA: src_a_s = rA;
      4'h9, 4'hB:             src_a_s = RRSP;
      default:                src_a_s = RNONE;
    endcase
    case (icode)
      4'h4, 4'h5, 4'h6:       src_b_s = rB;
      4'h8, 4'h9, 4'hA, 4'hB: src_b_s = RRSP;
      default:                src_b_s = RNONE;
    endcase
  end

  // Writeback destinations from the latched instruction; RNONE unless actually writing
  always_comb begin
    dst_e_s = RNONE;
    dst_m_s = RNONE;
    if (wb_en && !reset) begin
      case (icode_q_r)
        4'h2:                   dst_e_s = cnd ? rb_q_r : RNONE;
        4'h3, 4'h6:             dst_e_s = rb_q_r;
        4'h8, 4'h9, 4'hA, 4'hB: dst_e_s = RRSP;
        default:                dst_e_s = RNONE;
      endcase
      case (icode_q_r)
        4'h5, 4'hB: dst_m_s = ra_q_r;
        default:    dst_m_s = RNONE;
      endcase
    end else begin
      dst_e_s = RNONE;
      dst_m_s = RNONE;
    end
  end

  // Register reads with same-cycle writeback bypass (M has priority over E)
  always_comb begin
    rd_a_s = 64'd0;
    rd_b_s = 64'd0;
    for (int i = 0; i < 15; i++) begin
      rd_a_s = (src_a_s == 4'(i)) ? regs_r[i] : rd_a_s;
      rd_b_s = (src_b_s == 4'(i)) ? regs_r[i] : rd_b_s;
    end
    if (src_a_s != RNONE && src_a_s == dst_m_s) begin
      rd_a_s = valM;
    end else if (src_a_s != RNONE && src_a_s == dst_e_s) begin
      rd_a_s = valE;
    end else begin
      rd_a_s = rd_a_s;
    end
    if (src_b_s != RNONE && src_b_s == dst_m_s) begin
      rd_b_s = valM;
    end else if (src_b_s != RNONE && src_b_s == dst_e_s) begin
      rd_b_s = valE;
    end else begin
      rd_b_s = rd_b_s;
    end
  end

  // Register file writeback and decode latches
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) begin
        regs_r[i] <= 64'd0;
      end
      icode_q_r <= RNONE;
      ra_q_r    <= RNONE;
      rb_q_r    <= RNONE;
      srcA      <= RNONE;
      srcB      <= RNONE;
      valA      <= 64'd0;
      valB      <= 64'd0;
      inst_err  <= 1'b0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (dst_m_s == 4'(i)) begin
          regs_r[i] <= valM;
        end else if (dst_e_s == 4'(i)) begin
          regs_r[i] <= valE;
        end
      end
      if (dec_en) begin
        icode_q_r <= icode;
        ra_q_r    <= rA;
        rb_q_r    <= rB;
        srcA      <= src_a_s;
        srcB      <= src_b_s;
        valA      <= rd_a_s;
        valB      <= rd_b_s;
        inst_err  <= (icode > 4'hB);
      end
    end
  end

  assign dstE_wb = dst_e_s;
  assign dstM_wb = dst_m_s;
  assign rsp     = regs_r[4];

endmodule

// File: tb/tb_decode_writeback.sv
// Scoreboard bench for decode_writeback: an ISA-level register-file model predicts
// every cycle's destinations, decode outputs and rsp; a monitor pops and compares.
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dec_en = 1'b0;
  logic [3:0]  icode = 4'h0;
  logic [3:0]  rA = 4'hF;
  logic [3:0]  rB = 4'hF;
  logic        wb_en = 1'b0;
  logic        cnd = 1'b0;
  logic [63:0] valE = 64'd0;
  logic [63:0] valM = 64'd0;
  logic [63:0] valA, valB, rsp;
  logic [3:0]  srcA, srcB, dstE_wb, dstM_wb;
  logic        inst_err;

  decode_writeback dut (
    .clk(clk), .reset(reset), .dec_en(dec_en), .icode(icode), .rA(rA), .rB(rB),
    .wb_en(wb_en), .cnd(cnd), .valE(valE), .valM(valM),
    .valA(valA), .valB(valB), .srcA(srcA), .srcB(srcB),
    .dstE_wb(dstE_wb), .dstM_wb(dstM_wb), .inst_err(inst_err), .rsp(rsp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  sa;
    logic [3:0]  sb;
    logic [63:0] va;
    logic [63:0] vb;
    logic        err;
  } dec_t;

  typedef struct packed {
    logic [3:0] de;
    logic [3:0] dm;
  } dst_t;

  dec_t        dec_q[$];
  dst_t        dst_q[$];
  logic [63:0] rsp_q[$];

  // reference model state
  logic [63:0] m_regs [15];
  logic [3:0]  m_icode, m_ra, m_rb;
  dec_t        m_out;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_read(input logic [3:0] id);
    return (id == 4'hF) ? 64'd0 : m_regs[id];
  endfunction

  // ISA meaning: who reads what, and who writes what
  function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] a);
    if (ic == 4'h2 || ic == 4'h4 || ic == 4'h6 || ic == 4'hA) return a;
    if (ic == 4'h9 || ic == 4'hB) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] b);
    if (ic == 4'h4 || ic == 4'h5 || ic == 4'h6) return b;
    if (ic >= 4'h8 && ic <= 4'hB) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] b, input logic c);
    if (ic == 4'h2) return c ? b : 4'hF;
    if (ic == 4'h3 || ic == 4'h6) return b;
    if (ic >= 4'h8 && ic <= 4'hB) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] a);
    return (ic == 4'h5 || ic == 4'hB) ? a : 4'hF;
  endfunction

  // One cycle: drive inputs at negedge, advance model, queue expectations
  task automatic step(input logic rst, input logic de, input logic [3:0] ic,
                      input logic [3:0] a, input logic [3:0] b, input logic we,
                      input logic c, input logic [63:0] ve, input logic [63:0] vm);
    dst_t d;
    @(negedge clk);
    reset = rst; dec_en = de; icode = ic; rA = a; rB = b;
    wb_en = we; cnd = c; valE = ve; valM = vm;
    d.de = (we && !rst) ? m_dst_e(m_icode, m_rb, c) : 4'hF;
    d.dm = (we && !rst) ? m_dst_m(m_icode, m_ra) : 4'hF;
    dst_q.push_back(d);
    if (rst) begin
      for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
      m_icode = 4'hF; m_ra = 4'hF; m_rb = 4'hF;
      m_out = '{sa: 4'hF, sb: 4'hF, va: 64'd0, vb: 64'd0, err: 1'b0};
    end else begin
      // E then M, so M wins a conflict; decode then sees the freshly written file
      if (d.de != 4'hF) m_regs[d.de] = ve;
      if (d.dm != 4'hF) m_regs[d.dm] = vm;
      if (de) begin
        m_out.sa  = m_src_a(ic, a);
        m_out.sb  = m_src_b(ic, b);
        m_out.va  = m_read(m_out.sa);
        m_out.vb  = m_read(m_out.sb);
        m_out.err = (ic > 4'hB);
        m_icode = ic; m_ra = a; m_rb = b;
      end
    end
    dec_q.push_back(m_out);
    rsp_q.push_back(m_regs[4]);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 64'd0, 64'd0);
  endtask

  // Monitor: destinations before the edge, registered outputs after it
  initial begin
    dst_t d;
    dec_t e;
    logic [63:0] r;
    forever begin
      @(negedge clk); #2;
      if (dst_q.size() > 0) begin
        d = dst_q.pop_front();
        chk("dstE_wb", {60'd0, dstE_wb}, {60'd0, d.de});
        chk("dstM_wb", {60'd0, dstM_wb}, {60'd0, d.dm});
      end
      @(posedge clk); #1;
      if (dec_q.size() > 0) begin
        e = dec_q.pop_front();
        chk("srcA", {60'd0, srcA}, {60'd0, e.sa});
        chk("srcB", {60'd0, srcB}, {60'd0, e.sb});
        chk("valA", valA, e.va);
        chk("valB", valB, e.vb);
        chk("inst_err", {63'd0, inst_err}, {63'd0, e.err});
      end
      if (rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        chk("rsp", rsp, r);
      end
    end
  end

  initial begin
    for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
    m_icode = 4'hF; m_ra = 4'hF; m_rb = 4'hF;
    m_out = '{sa: 4'hF, sb: 4'hF, va: 64'd0, vb: 64'd0, err: 1'b0};

    step(1'b1, 1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 64'd0, 64'd0);
    step(1'b1, 1'b1, 4'h6, 4'h1, 4'h2, 1'b1, 1'b1, 64'd5, 64'd6);
    @(posedge clk); #1;
    chk("reset_srcA", {60'd0, srcA}, 64'hF);
    chk("reset_rsp", rsp, 64'd0);

    // irmovq to %rdx, then OPq reading it
    step(1'b0, 1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 1'b0, 64'd0, 64'd0);
    step(1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 64'd4, 64'd0);
    step(1'b0, 1'b1, 4'h6, 4'h2, 4'h3, 1'b0, 1'b0, 64'd0, 64'd0);
    @(posedge clk); #1;
    chk("opq_valA", valA, 64'd4);
    chk("opq_valB", valB, 64'd0);

    // conditional move, not taken then taken
    step(1'b0, 1'b1, 4'h2, 4'h0, 4'h1, 1'b0, 1'b0, 64'd0, 64'd0);
    step(1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 64'd7, 64'd0);
    step(1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 1'b1, 1'b1, 64'd7, 64'd0);
    step(1'b0, 1'b1, 4'h2, 4'h1, 4'hF, 1'b0, 1'b0, 64'd0, 64'd0);
    @(posedge clk); #1;
    chk("cmov_reg1", valA, 64'd7);

    // preload rsp, then popq %rsp conflict
    step(1'b0, 1'b1, 4'h3, 4'hF, 4'h4, 1'b0, 1'b0, 64'd0, 64'd0);
    step(1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 64'h10, 64'd0);
    step(1'b0, 1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 1'b0, 64'd0, 64'd0);
    @(posedge clk); #1;
    chk("popq_valA", valA, 64'h10);
    step(1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 64'h18, 64'h55);
    @(posedge clk); #1;
    chk("popq_rsp", rsp, 64'h55);

    // mrmovq writeback bypassed into a same-cycle pushq decode
    step(1'b0, 1'b1, 4'h5, 4'h5, 4'hF, 1'b0, 1'b0, 64'd0, 64'd0);
    step(1'b0, 1'b1, 4'hA, 4'h5, 4'hF, 1'b1, 1'b0, 64'd0, 64'h99);
    @(posedge clk); #1;
    chk("bypass_valA", valA, 64'h99);
    chk("bypass_valB", valB, 64'h55);

    // invalid icode
    step(1'b0, 1'b1, 4'hC, 4'h4, 4'h4, 1'b0, 1'b0, 64'd0, 64'd0);
    @(posedge clk); #1;
    chk("inv_err", {63'd0, inst_err}, 64'd1);
    step(1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 1'b1, 1'b1, 64'd1, 64'd1);
    idle();

    // reset mid-instruction drops the pending writeback
    step(1'b0, 1'b1, 4'h9, 4'hF, 4'hF, 1'b0, 1'b0, 64'd0, 64'd0);
    step(1'b1, 1'b0, 4'h0, 4'hF, 4'hF, 1'b1, 1'b1, 64'h77, 64'h77);
    step(1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 1'b1, 1'b1, 64'h77, 64'h77);
    @(posedge clk); #1;
    chk("rst_mid_rsp", rsp, 64'd0);
    chk("rst_mid_valA", valA, 64'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           {$urandom, $urandom}, {$urandom, $urandom});
    end
    idle();
    idle();
    @(posedge clk); #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
